// File: rtl/pll_seq_pkg.sv
// PLL lock sequencer shared types.
// State encoding and status counter widths.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_SETTLE,
    S_RUN,
    S_HALT
  } state_e;

  localparam int RETRY_W = 3;
  localparam int LOSS_W  = 8;

  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;
  localparam logic [LOSS_W-1:0]  LOSS_SAT  = '1;

endpackage

// File: rtl/pll_lock_sequencer_sync2.sv
// Generic 2-flop single-bit synchroniser.
// Reset value is a parameter so idle-high signals can be synchronised too.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  // Two-stage shift toward the destination domain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ff_q <= {2{RST_VAL}};
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer for the 50 MHz reference domain.
// Holds core reset until lock is stable, retries and reports faults.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int SETTLE_CYCLES = 50000,
  parameter int MAX_RETRY     = 7,
  parameter int CNT_W         = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               core_reset,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt
);

  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_1   = RETRY_W'(1);
  localparam logic [LOSS_W-1:0]  LOSS_1    = LOSS_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               fault_q, fault_d;
  logic               pll_rst_q, pll_rst_d;
  logic               core_rst_q, core_rst_d;
  logic               ready_q, ready_d;
  logic               lk;

  sync2 #(
    .RST_VAL(1'b0)
  ) u_lock_sync (
    .clk_i(clk),
    .rst_i(reset),
    .d_i  (pll_locked),
    .q_o  (lk)
  );

  // State, counter and status registers; outputs are registered for
  // glitch-free reset lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RESET_PLL;
      cnt_q      <= RST_LD;
      retry_q    <= '0;
      loss_q     <= '0;
      fault_q    <= 1'b0;
      pll_rst_q  <= 1'b1;
      core_rst_q <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      fault_q    <= fault_d;
      pll_rst_q  <= pll_rst_d;
      core_rst_q <= core_rst_d;
      ready_q    <= ready_d;
    end
  end

  // Next state: restart outranks lock changes and counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    fault_d = fault_q;
    if (restart && state_q != S_HALT) begin
      state_d = S_RESET_PLL;
      cnt_d   = RST_LD;
    end else begin
      unique case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == '0) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = TO_LD;
          end else begin
            cnt_d = cnt_q - CNT_1;
          end
        end
        S_WAIT_LOCK: begin
          if (lk) begin
            state_d = S_SETTLE;
            cnt_d   = SET_LD;
          end else if (cnt_q == '0) begin
            if (retry_q != RETRY_SAT) begin
              retry_d = retry_q + RETRY_1;
            end
            if (retry_q == RETRY_MAX) begin
              fault_d = 1'b1;
              state_d = S_HALT;
              cnt_d   = '0;
            end else begin
              state_d = S_RESET_PLL;
              cnt_d   = RST_LD;
            end
          end else begin
            cnt_d = cnt_q - CNT_1;
          end
        end
        S_SETTLE: begin
          if (!lk) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = TO_LD;
          end else if (cnt_q == '0) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q - CNT_1;
          end
        end
        S_RUN: begin
          if (!lk) begin
            if (loss_q != LOSS_SAT) begin
              loss_d = loss_q + LOSS_1;
            end
            state_d = S_RESET_PLL;
            cnt_d   = RST_LD;
          end
        end
        S_HALT: begin
          if (restart) begin
            fault_d = 1'b0;
            retry_d = '0;
            state_d = S_RESET_PLL;
            cnt_d   = RST_LD;
          end
        end
        default: begin
          state_d = S_RESET_PLL;
          cnt_d   = RST_LD;
        end
      endcase
    end
  end

  // Output decode from the next state so each output is a plain flop.
  always_comb begin
    pll_rst_d  = (state_d == S_RESET_PLL) || (state_d == S_HALT);
    core_rst_d = (state_d != S_RUN);
    ready_d    = (state_d == S_RUN);
  end

  assign pll_rst    = pll_rst_q;
  assign core_reset = core_rst_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign retry_cnt  = retry_q;
  assign loss_cnt   = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer.
// Table rows, directed corner sequences and a random run against a model.
module tb_pll_lock_sequencer;

  localparam int RSTC = 4;
  localparam int TOC  = 20;
  localparam int SETC = 8;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       restart = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, core_reset, ready, fault;
  logic [2:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pll_lock_sequencer #(
    .RST_CYCLES   (RSTC),
    .LOCK_TIMEOUT (TOC),
    .SETTLE_CYCLES(SETC),
    .MAX_RETRY    (MAXR),
    .CNT_W        (20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .core_reset(core_reset),
    .ready     (ready),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: named phases with elapsed-time counters and an
  // explicit two-deep delay line for the lock input.
  localparam int P_RST = 0, P_WAIT = 1, P_SET = 2, P_RUN = 3, P_HALT = 4;
  int m_ph = P_RST;
  int m_age = 0;
  int m_retry = 0;
  int m_loss = 0;
  bit m_fault = 0;
  bit m_dly[2] = '{0, 0};

  function automatic void enter(int ph);
    m_ph  = ph;
    m_age = 0;
  endfunction

  function automatic void model_step(bit r, bit rs, bit raw);
    bit lk;
    int old_retry;
    lk = m_dly[1];
    if (r) begin
      enter(P_RST);
      m_retry = 0;
      m_loss  = 0;
      m_fault = 0;
      m_dly   = '{0, 0};
      return;
    end
    m_dly[1] = m_dly[0];
    m_dly[0] = raw;
    if (rs && m_ph != P_HALT) begin
      enter(P_RST);
      return;
    end
    case (m_ph)
      P_RST: if (m_age == RSTC - 1) enter(P_WAIT); else m_age++;
      P_WAIT: begin
        if (lk) enter(P_SET);
        else if (m_age == TOC - 1) begin
          old_retry = m_retry;
          m_retry = (m_retry < 7) ? m_retry + 1 : 7;
          if (old_retry == MAXR) begin
            m_fault = 1;
            enter(P_HALT);
          end else enter(P_RST);
        end else m_age++;
      end
      P_SET: begin
        if (!lk) enter(P_WAIT);
        else if (m_age == SETC - 1) begin
          m_retry = 0;
          enter(P_RUN);
        end else m_age++;
      end
      P_RUN: begin
        if (!lk) begin
          m_loss = (m_loss < 255) ? m_loss + 1 : 255;
          enter(P_RST);
        end
      end
      default: begin
        if (rs) begin
          m_fault = 0;
          m_retry = 0;
          enter(P_RST);
        end
      end
    endcase
  endfunction

  function automatic logic [14:0] model_out();
    logic pr, cr, rd;
    pr = (m_ph == P_RST) || (m_ph == P_HALT);
    cr = (m_ph != P_RUN);
    rd = (m_ph == P_RUN);
    return {pr, cr, rd, m_fault, 3'(m_retry), 8'(m_loss)};
  endfunction

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  // One clock: drive inputs, advance model, compare after the edge.
  task automatic step(input bit r, input bit rs, input bit raw);
    logic [14:0] act, exp;
    reset      = r;
    restart    = rs;
    pll_locked = raw;
    model_step(r, rs, raw);
    @(posedge clk);
    #1;
    exp = model_out();
    act = {pll_rst, core_reset, ready, fault, retry_cnt, loss_cnt};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL model @%0t: got %b, expected %b", $time, act, exp);
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0);
    step(1, 0, 0);
  endtask

  task automatic run_to_ready(input int budget, output int n);
    n = 0;
    while (!ready && n < budget) begin
      step(0, 0, 1);
      n++;
    end
    if (!ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: got ready=0 after %0d, expected 1", n);
    end
  endtask

  typedef struct {
    bit r;
    bit rs;
    bit lk;
    int n;
    bit prst;
    bit crst;
    bit rdy;
    int retry;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n, d, h, k, fault_at, prev;
    int edges[3];
    bit early, retry_bad, raw;
    int seg;

    tbl[0] = '{1, 0, 0, 2,  1, 1, 0, 0};
    tbl[1] = '{0, 0, 0, 3,  1, 1, 0, 0};
    tbl[2] = '{0, 0, 0, 1,  0, 1, 0, 0};
    tbl[3] = '{0, 0, 0, 9,  0, 1, 0, 0};
    tbl[4] = '{0, 0, 1, 10, 0, 1, 0, 0};
    tbl[5] = '{0, 0, 1, 1,  0, 0, 1, 0};

    // Clean bring-up, table driven.
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        step(tbl[i].r, tbl[i].rs, tbl[i].lk);
      end
      chk($sformatf("tbl%0d.pll_rst", i), int'(pll_rst), int'(tbl[i].prst));
      chk($sformatf("tbl%0d.core_reset", i), int'(core_reset),
          int'(tbl[i].crst));
      chk($sformatf("tbl%0d.ready", i), int'(ready), int'(tbl[i].rdy));
      chk($sformatf("tbl%0d.retry", i), int'(retry_cnt), tbl[i].retry);
    end

    // Timeout retries then fault, then restart out of HALT.
    do_reset();
    chk("rst.loss", int'(loss_cnt), 0);
    chk("rst.fault", int'(fault), 0);
    k = 0;
    fault_at = 0;
    for (int i = 1; i <= 200 && fault_at == 0; i++) begin
      prev = int'(retry_cnt);
      step(0, 0, 0);
      if (int'(retry_cnt) != prev && k < 3) begin
        edges[k] = i;
        k++;
      end
      if (fault) fault_at = i;
    end
    chk("to.changes", k, 3);
    chk("to.retry1", edges[0], 24);
    chk("to.retry2", edges[1], 48);
    chk("to.retry3", edges[2], 72);
    chk("to.fault_at", fault_at, 96);
    chk("to.halt_pll_rst", int'(pll_rst), 1);
    step(0, 0, 0);
    chk("halt.sticky", int'(fault), 1);
    step(0, 1, 0);
    chk("halt.restart_fault", int'(fault), 0);
    chk("halt.restart_retry", int'(retry_cnt), 0);
    chk("halt.restart_pll_rst", int'(pll_rst), 1);

    // Settle bounce.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    early = 0;
    retry_bad = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1);
      early |= ready;
      retry_bad |= (retry_cnt != 3'd0);
    end
    step(0, 0, 0);
    early |= ready;
    n = 0;
    while (!ready && n < 60) begin
      step(0, 0, 1);
      n++;
      retry_bad |= (retry_cnt != 3'd0);
    end
    chk("bounce.early_ready", int'(early), 0);
    chk("bounce.retry", int'(retry_bad), 0);
    chk("bounce.latency", n, 11);

    // Lock loss in RUN, repeated to saturation.
    do_reset();
    run_to_ready(60, n);
    for (int it = 0; it < 256; it++) begin
      step(0, 0, 0);
      d = 1;
      while (!core_reset && d < 10) begin
        step(0, 0, 1);
        d++;
      end
      if (it == 0) begin
        chk("loss.first_cnt", int'(loss_cnt), 1);
        chk("loss.core_reset_within3", int'(d <= 3), 1);
      end
      run_to_ready(60, n);
    end
    chk("loss.saturate", int'(loss_cnt), 255);

    // Restart coincident with lk drop in RUN.
    do_reset();
    run_to_ready(60, n);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 1, 1);
    chk("rs_drop.loss", int'(loss_cnt), 0);
    chk("rs_drop.core_reset", int'(core_reset), 1);
    h = 1;
    while (pll_rst && h < 20) begin
      step(0, 0, 1);
      h++;
    end
    chk("rs_drop.rst_len", h - 1, 4);
    run_to_ready(60, n);
    chk("rs_drop.loss_after", int'(loss_cnt), 0);

    // Reset during SETTLE.
    do_reset();
    for (int i = 0; i < 7; i++) step(0, 0, 1);
    step(1, 0, 1);
    chk("settle_rst.outs",
        int'({pll_rst, core_reset, ready, fault, retry_cnt, loss_cnt}),
        int'(15'b110_0_000_00000000));
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 1);
      chk($sformatf("settle_rst.pll_rst%0d", i), int'(pll_rst),
          int'(i < 4));
    end

    // Randomised run against the model.
    do_reset();
    seg = 0;
    raw = 1;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        seg = $urandom_range(1, 40);
        raw = ($urandom_range(0, 3) != 0);
      end
      seg--;
      step($urandom_range(0, 699) == 0, $urandom_range(0, 149) == 0, raw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
